// File: rtl/matrix_loc_scan_if.sv
// ============================================================================
// Module   : matrix_loc_scan_if
// Purpose  : Control/handshake bundle between the scan controller and the
//            matrix element sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface matrix_loc_scan_if #(
  parameter int IDX_W = 4,
  parameter int LOC_W = 4
);
  logic [1:0]       mode;
  logic             col_major;
  logic             start;
  logic             step;
  logic             ready;
  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;
  logic [LOC_W-1:0] matrix_loc;
  logic             loc_valid;
  logic             last;
  logic             wrap;
  logic             busy;
  logic             done;

  modport master (
    output mode, col_major, start, step, ready,
    input  row, col, matrix_loc, loc_valid, last, wrap, busy, done
  );

  modport slave (
    input  mode, col_major, start, step, ready,
    output row, col, matrix_loc, loc_valid, last, wrap, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/matrix_loc_scan.sv
// ============================================================================
// Module   : matrix_loc_scan
// Purpose  : Walks a ROWS x COLS matrix in row- or column-major order and
//            presents row/col indices plus a location code per element.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module matrix_loc_scan #(
  parameter int               ROWS     = 2,
  parameter int               COLS     = 2,
  parameter int               IDX_W    = 4,
  parameter int               LOC_W    = 4,
  parameter logic [LOC_W-1:0] LOC_BASE = 4'hA,
  parameter int               PRESCALE = 1
) (
  input  wire logic          clk,
  input  wire logic          btnC_n,
  matrix_loc_scan_if.slave   bus
);

  localparam logic [1:0] c_MODE_FREE = 2'b00;
  localparam logic [1:0] c_MODE_PASS = 2'b01;
  localparam logic [1:0] c_MODE_STEP = 2'b10;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  localparam int               c_PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PS_W-1:0] c_PS_LAST  = c_PS_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  c_ROW_LAST = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0]  c_COL_LAST = IDX_W'(COLS - 1);

  logic [IDX_W-1:0]  row_q, row_d;
  logic [IDX_W-1:0]  col_q, col_d;
  logic [c_PS_W-1:0] ps_q, ps_d;
  logic              pend_q, pend_d;
  logic [0:0]        state_q, state_d;
  logic              loc_valid_q, loc_valid_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;
  logic              step_q;
  logic [1:0]        mode_q;

  logic w_mode_chg, w_last, w_count, w_tick, w_adv_auto, w_adv_step, w_adv;

  always_comb begin
    w_mode_chg = (bus.mode != mode_q);
    // The final element is (ROWS-1, COLS-1) in both traversal orders.
    w_last     = (row_q == c_ROW_LAST) && (col_q == c_COL_LAST);
    w_count    = !w_mode_chg &&
                 ((bus.mode == c_MODE_FREE) ||
                  ((bus.mode == c_MODE_PASS) && (state_q == c_ST_RUN)));
    w_tick     = w_count && (ps_q == c_PS_LAST);
    w_adv_auto = w_count && (w_tick || pend_q) && bus.ready && loc_valid_q;
    w_adv_step = !w_mode_chg && (bus.mode == c_MODE_STEP) && bus.step && !step_q;
    w_adv      = w_adv_auto || w_adv_step;
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (w_mode_chg) begin
      row_d = '0;
      col_d = '0;
    end else if (w_adv) begin
      if (w_last) begin
        row_d = '0;
        col_d = '0;
      end else if (bus.col_major) begin
        if (row_q == c_ROW_LAST) begin
          row_d = '0;
          col_d = col_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        if (col_q == c_COL_LAST) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ps_d   = w_count ? (w_tick ? '0 : ps_q + 1'b1) : '0;
    // At most one deferred tick is remembered while ready is low.
    pend_d = w_count && !w_adv_auto && (w_tick || pend_q);
    wrap_d = w_adv_auto && w_last && (bus.mode == c_MODE_FREE);
    done_d = w_adv_auto && w_last && (bus.mode == c_MODE_PASS);

    state_d = state_q;
    if (w_mode_chg || (bus.mode != c_MODE_PASS)) begin
      state_d = c_ST_IDLE;
    end else begin
      case (state_q)
        c_ST_IDLE: if (bus.start && !done_q) state_d = c_ST_RUN;
        c_ST_RUN:  if (done_d)               state_d = c_ST_IDLE;
        default:                             state_d = c_ST_IDLE;
      endcase
    end

    loc_valid_d = (bus.mode == c_MODE_PASS) ? (state_d == c_ST_RUN) : 1'b1;
  end

  always_ff @(posedge clk or negedge btnC_n) begin
    if (!btnC_n) begin
      row_q       <= '0;
      col_q       <= '0;
      ps_q        <= '0;
      pend_q      <= 1'b0;
      state_q     <= c_ST_IDLE;
      loc_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
      step_q      <= 1'b0;
      mode_q      <= c_MODE_FREE;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      ps_q        <= ps_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      loc_valid_q <= loc_valid_d;
      wrap_q      <= wrap_d;
      done_q      <= done_d;
      step_q      <= bus.step;
      mode_q      <= bus.mode;
    end
  end

  assign bus.row        = row_q;
  assign bus.col        = col_q;
  assign bus.matrix_loc = LOC_W'(32'(LOC_BASE) + 32'(row_q) * 32'(COLS) + 32'(col_q));
  assign bus.loc_valid  = loc_valid_q;
  assign bus.last       = w_last;
  assign bus.wrap       = wrap_q;
  assign bus.busy       = (state_q == c_ST_RUN);
  assign bus.done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_loc_scan.sv
// ============================================================================
// Module   : tb_matrix_loc_scan
// Purpose  : Randomised bench for matrix_loc_scan; three parameterisations
//            share stimulus and are checked against an element-position model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_matrix_loc_scan;

  typedef struct {
    int rows; int cols; int presc; int base;
    int r; int c; int cnt;
    bit pend; bit valid; bit wrap; bit done; bit run;
    int mode_p; bit step_p;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] s_mode  = 2'b00;
  logic       s_cm    = 1'b0;
  logic       s_start = 1'b0;
  logic       s_step  = 1'b0;
  logic       s_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  mdl_t m [3];

  matrix_loc_scan_if #(.IDX_W(4), .LOC_W(4)) ifa ();
  matrix_loc_scan_if #(.IDX_W(4), .LOC_W(4)) ifb ();
  matrix_loc_scan_if #(.IDX_W(4), .LOC_W(4)) ifc ();

  assign ifa.mode = s_mode;  assign ifa.col_major = s_cm;  assign ifa.start = s_start;
  assign ifa.step = s_step;  assign ifa.ready = s_ready;
  assign ifb.mode = s_mode;  assign ifb.col_major = s_cm;  assign ifb.start = s_start;
  assign ifb.step = s_step;  assign ifb.ready = s_ready;
  assign ifc.mode = s_mode;  assign ifc.col_major = s_cm;  assign ifc.start = s_start;
  assign ifc.step = s_step;  assign ifc.ready = s_ready;

  matrix_loc_scan u_dut_a (.clk(clk), .btnC_n(rst_n), .bus(ifa));

  matrix_loc_scan #(.ROWS(2), .COLS(3), .IDX_W(4), .LOC_W(4), .LOC_BASE(4'hA), .PRESCALE(4))
    u_dut_b (.clk(clk), .btnC_n(rst_n), .bus(ifb));

  matrix_loc_scan #(.ROWS(1), .COLS(1), .IDX_W(4), .LOC_W(4), .LOC_BASE(4'h3), .PRESCALE(2))
    u_dut_c (.clk(clk), .btnC_n(rst_n), .bus(ifc));

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_rst(input mdl_t x);
    mdl_t n = x;
    n.r = 0; n.c = 0; n.cnt = 0; n.pend = 0; n.valid = 0;
    n.wrap = 0; n.done = 0; n.run = 0; n.mode_p = 0; n.step_p = 0;
    return n;
  endfunction

  // One clock of the behavioural model: positions are linear indices in the
  // currently selected order, re-derived from (r,c) at every advance.
  function automatic mdl_t mdl_next(input mdl_t x, input int mode, input bit cm,
                                    input bit start, input bit step, input bit ready);
    mdl_t n = x;
    int   n_el = x.rows * x.cols;
    int   pos;
    bit   counting, tick, go, was_last;
    n.wrap = 0;
    n.done = 0;
    if (mode != x.mode_p) begin
      n.r = 0; n.c = 0; n.cnt = 0; n.pend = 0; n.run = 0;
    end else begin
      counting = (mode == 0) || (mode == 1 && x.run);
      tick     = counting && (x.cnt == x.presc - 1);
      n.cnt    = counting ? (x.cnt + 1) % x.presc : 0;
      go       = (mode == 2) ? (step && !x.step_p)
                             : (counting && (tick || x.pend) && ready && x.valid);
      n.pend   = counting && !go && (tick || x.pend);
      if (go) begin
        pos      = cm ? (x.c * x.rows + x.r) : (x.r * x.cols + x.c);
        was_last = (pos == n_el - 1);
        pos      = (pos + 1) % n_el;
        if (cm) begin n.r = pos % x.rows; n.c = pos / x.rows; end
        else    begin n.r = pos / x.cols; n.c = pos % x.cols; end
        if (was_last && mode == 0) n.wrap = 1;
        if (was_last && mode == 1) begin n.run = 0; n.done = 1; end
      end
      if (mode == 1 && !x.run && start && !x.done) n.run = 1;
      if (mode != 1) n.run = 0;
    end
    n.valid  = (mode == 1) ? n.run : 1'b1;
    n.mode_p = mode;
    n.step_p = step;
    return n;
  endfunction

  task automatic cmp_dut(input string id, input mdl_t x, input int row, input int col,
                         input int loc, input int valid, input int last, input int wrap,
                         input int busy, input int done);
    chk({id, "_row"},   row,   x.r);
    chk({id, "_col"},   col,   x.c);
    chk({id, "_loc"},   loc,   (x.base + x.r * x.cols + x.c) % 16);
    chk({id, "_valid"}, valid, int'(x.valid));
    chk({id, "_last"},  last,  int'(x.r == x.rows - 1 && x.c == x.cols - 1));
    chk({id, "_wrap"},  wrap,  int'(x.wrap));
    chk({id, "_busy"},  busy,  int'(x.run));
    chk({id, "_done"},  done,  int'(x.done));
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int k = 0; k < 3; k++)
      m[k] = rst_n ? mdl_next(m[k], int'(s_mode), s_cm, s_start, s_step, s_ready) : mdl_rst(m[k]);
    #1;
    cmp_dut("a", m[0], ifa.row, ifa.col, ifa.matrix_loc, ifa.loc_valid, ifa.last, ifa.wrap, ifa.busy, ifa.done);
    cmp_dut("b", m[1], ifb.row, ifb.col, ifb.matrix_loc, ifb.loc_valid, ifb.last, ifb.wrap, ifb.busy, ifb.done);
    cmp_dut("c", m[2], ifc.row, ifc.col, ifc.matrix_loc, ifc.loc_valid, ifc.last, ifc.wrap, ifc.busy, ifc.done);
  endtask

  task automatic chk_reset_vals();
    chk("rst_a_loc",   ifa.matrix_loc, 'hA);
    chk("rst_a_row",   ifa.row, 0);
    chk("rst_a_valid", ifa.loc_valid, 0);
    chk("rst_a_busy",  ifa.busy, 0);
    chk("rst_a_done",  ifa.done, 0);
    chk("rst_b_loc",   ifb.matrix_loc, 'hA);
    chk("rst_b_col",   ifb.col, 0);
    chk("rst_b_busy",  ifb.busy, 0);
    chk("rst_b_done",  ifb.done, 0);
    chk("rst_c_loc",   ifc.matrix_loc, 'h3);
    chk("rst_c_wrap",  ifc.wrap, 0);
  endtask

  initial begin
    m[0] = '{rows:2, cols:2, presc:1, base:'hA, default:0};
    m[1] = '{rows:2, cols:3, presc:4, base:'hA, default:0};
    m[2] = '{rows:1, cols:1, presc:2, base:'h3, default:0};
    for (int k = 0; k < 3; k++) m[k] = mdl_rst(m[k]);

    repeat (3) cyc();
    chk_reset_vals();
    rst_n = 1'b1;

    // Free-run, row-major then column-major, ready held high.
    repeat (20) cyc();
    s_cm = 1'b1;
    repeat (20) cyc();

    // Random back-pressure with occasional order changes.
    for (int i = 0; i < 60; i++) begin
      s_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) s_cm = ~s_cm;
      cyc();
    end

    // Long ready-low stretch then release.
    s_ready = 1'b0;
    repeat (10) cyc();
    s_ready = 1'b1;
    repeat (12) cyc();

    // Single pass with stray start pulses during the run.
    s_mode = 2'b01;
    repeat (2) cyc();
    s_start = 1'b1; cyc(); s_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      s_start = ($urandom_range(0, 7) == 0);
      s_ready = ($urandom_range(0, 4) != 0);
      cyc();
    end
    s_start = 1'b0; s_ready = 1'b1;

    // Manual step: held-high step gives one advance per rising edge.
    s_mode = 2'b10;
    repeat (2) cyc();
    for (int j = 0; j < 4; j++) begin
      s_step = 1'b1; repeat (5) cyc();
      s_step = 1'b0; repeat (2) cyc();
    end
    for (int i = 0; i < 30; i++) begin
      s_step = 1'($urandom_range(0, 1));
      cyc();
    end

    // Hold: everything frozen regardless of inputs.
    s_mode = 2'b11;
    for (int i = 0; i < 12; i++) begin
      s_step  = 1'($urandom_range(0, 1));
      s_ready = 1'($urandom_range(0, 1));
      s_start = 1'($urandom_range(0, 1));
      cyc();
    end

    // Fully random traffic including mode changes mid-operation.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) s_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) s_cm = ~s_cm;
      s_start = ($urandom_range(0, 7) == 0);
      s_step  = 1'($urandom_range(0, 1));
      s_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // Asynchronous reset in the middle of a single pass.
    s_mode = 2'b01; s_ready = 1'b1; s_start = 1'b0;
    repeat (2) cyc();
    s_start = 1'b1; cyc(); s_start = 1'b0;
    repeat (3) cyc();
    chk("pre_rst_busy", ifb.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals();
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (10) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
